// File: rtl/column_norm_init.sv
// rtl/column_norm_init.sv - per-column sum of squares over one H frame, then argmin search
// Squares are registered one stage before accumulation, so SEARCH waits one cycle for it to drain.
`ifndef WL
`define WL 16
`endif
`ifndef FWL
`define FWL 12
`endif
`ifndef COLNORM_WL
`define COLNORM_WL 16
`endif
`ifndef COLNORM_FWL
`define COLNORM_FWL 10
`endif

module column_norm_init #(
  parameter int NROW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*`WL-1:0]         row_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [8*`COLNORM_WL-1:0] colnorm_o,
  output logic [2:0]               min_idx_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);
  localparam int CW = `COLNORM_WL;
  localparam int SH = `FWL - `COLNORM_FWL;
  localparam logic [CW-1:0]          MAXP   = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [2*CW-1:0] MAXP_W = {{(CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic [2:0]             LAST_ROW = 3'(NROW - 1);

  typedef enum logic [1:0] {S_ACC, S_SEARCH, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          w_beat;
  logic [2:0]    r_row_cnt, r_cand, r_sidx;
  logic          r_sq_vld;
  logic [CW-1:0] r_acc [8];
  logic [CW-1:0] r_sq  [8];
  logic [CW-1:0] w_sq  [8];
  logic [CW-1:0] w_acc_nxt [8];

  for (genvar k = 0; k < 8; k++) begin : g_col
    logic signed [`WL-1:0]   w_h;
    logic signed [2*CW-1:0]  w_hc, w_p, w_s;
    logic [CW:0]             w_sum;

    assign w_h  = row_i[k*`WL +: `WL];
    assign w_hc = (2*CW)'(w_h >>> SH);
    assign w_p  = w_hc * w_hc;
    assign w_s  = w_p >>> `COLNORM_FWL;
    assign w_sq[k] = (w_s > MAXP_W) ? MAXP : w_s[CW-1:0];

    assign w_sum = {1'b0, r_acc[k]} + {1'b0, r_sq[k]};
    assign w_acc_nxt[k] = (w_sum > {1'b0, MAXP}) ? MAXP : w_sum[CW-1:0];

    assign colnorm_o[k*CW +: CW] = r_acc[k];
  end

  assign in_ready_o  = (r_state == S_ACC);
  assign out_valid_o = (r_state == S_DONE);
  assign min_idx_o   = r_cand;

  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    case (r_state)
      S_ACC: begin
        w_beat = in_valid_i;
        if (w_beat && (r_row_cnt == LAST_ROW)) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        if (!r_sq_vld && (r_sidx == 3'd7)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) w_state_nxt = S_ACC;
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt <= 3'd0;
      r_cand    <= 3'd0;
      r_sidx    <= 3'd1;
      r_sq_vld  <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        r_acc[k] <= '0;
        r_sq[k]  <= '0;
      end
    end else begin
      r_sq_vld <= w_beat;
      if (w_beat) begin
        for (int k = 0; k < 8; k++) r_sq[k] <= w_sq[k];
        if (r_row_cnt == LAST_ROW) begin
          r_row_cnt <= 3'd0;
          r_cand    <= 3'd0;
          r_sidx    <= 3'd1;
        end else begin
          r_row_cnt <= r_row_cnt + 3'd1;
        end
      end
      // The pending square of the last row lands first; the scan starts once it has.
      if (r_sq_vld) begin
        for (int k = 0; k < 8; k++) r_acc[k] <= w_acc_nxt[k];
      end else if (r_state == S_SEARCH) begin
        if (r_acc[r_sidx] < r_acc[r_cand]) r_cand <= r_sidx;
        r_sidx <= r_sidx + 3'd1;
      end else if ((r_state == S_DONE) && out_ready_i) begin
        for (int k = 0; k < 8; k++) r_acc[k] <= '0;
      end
    end
  end
endmodule
